// File: rtl/core_types_pkg.sv
// Shared front-end types and sizes for the upper-PC table (UPCT) and its PLRU.
package core_types_pkg;

  localparam int XLEN                       = 32;
  localparam int UPPER_PC_TABLE_ENTRIES     = 8;
  localparam int LOG_UPPER_PC_TABLE_ENTRIES = 3;
  localparam int UPPER_PC_WIDTH             = 19;
  localparam int UPPER_PC_LSB               = XLEN - UPPER_PC_WIDTH;
  localparam int PLRU_NODES                 = UPPER_PC_TABLE_ENTRIES - 1;

  typedef logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] upct_idx_t;
  typedef logic [UPPER_PC_WIDTH-1:0]             upper_PC_t;
  typedef logic [PLRU_NODES-1:0]                 plru_state_t;

  function automatic upper_PC_t upper_of(input logic [XLEN-1:0] pc);
    return pc[XLEN-1:UPPER_PC_LSB];
  endfunction

endpackage

// File: rtl/plru_8way.sv
// Combinational 8-way tree-PLRU: applies up to two ordered touches and picks the victim.
// Node 0 is the root; node 1/2 cover leaves 0-3/4-7; nodes 3..6 cover leaf pairs. 0 = LRU on the left.
module plru_8way
  import core_types_pkg::*;
(
  input  plru_state_t state,
  input  logic        touch0_valid,
  input  upct_idx_t   touch0_index,
  input  logic        touch1_valid,
  input  upct_idx_t   touch1_index,
  output plru_state_t next_state,
  output upct_idx_t   victim
);

  function automatic plru_state_t touch(input plru_state_t s, input upct_idx_t idx);
    plru_state_t r;
    logic [2:0]  mid_node;
    logic [2:0]  leaf_node;
    r         = s;
    mid_node  = 3'd1 + {2'b00, idx[2]};
    leaf_node = 3'd3 + {1'b0, idx[2:1]};
    r[0]         = ~idx[2];
    r[mid_node]  = ~idx[1];
    r[leaf_node] = ~idx[0];
    return r;
  endfunction

  logic [2:0] mid_sel;
  logic [2:0] leaf_sel;

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    next_state = state;
    if (touch0_valid) next_state = touch(next_state, touch0_index);
    // The second touch wins on any node both paths share.
    if (touch1_valid) next_state = touch(next_state, touch1_index);
  end

  always_comb begin
    mid_sel  = 3'd1 + {2'b00, state[0]};
    leaf_sel = 3'd3 + {1'b0, state[0], state[mid_sel]};
    victim   = {state[0], state[mid_sel], state[leaf_sel]};
  end

endmodule

// File: rtl/upct_encoder.sv
// Upper-PC table: encodes branch targets into 3-bit indices and decodes indices back to PC[31:13].
// Optional macro UPCT_PERF_COUNTERS_EN adds saturating hit_count / miss_count outputs.
module upct_encoder
  import core_types_pkg::*;
(
  input  logic            CLK,
  input  logic            nRST,
  input  logic            read_valid,
  input  upct_idx_t       read_index,
  output upper_PC_t       read_upper_PC,
  input  logic            update0_valid,
  input  logic [XLEN-1:0] update0_target_full_PC,
  output logic            update1_valid,
  output upct_idx_t       update1_upct_index,
  output logic            update1_hit
`ifdef UPCT_PERF_COUNTERS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  upper_PC_t                         tag_q [UPPER_PC_TABLE_ENTRIES];
  upper_PC_t                         tag_d [UPPER_PC_TABLE_ENTRIES];
  logic [UPPER_PC_TABLE_ENTRIES-1:0] valid_q, valid_d;
  plru_state_t                       plru_q, plru_d;
  upper_PC_t                         read_upper_PC_q, read_upper_PC_d;
  logic                              update1_valid_q, update1_valid_d;
  upct_idx_t                         update1_upct_index_q, update1_upct_index_d;
  logic                              update1_hit_q, update1_hit_d;

  upper_PC_t   enc_tag;
  logic        enc_hit;
  upct_idx_t   hit_index;
  upct_idx_t   free_index;
  upct_idx_t   plru_victim;
  upct_idx_t   victim_index;
  upct_idx_t   chosen_index;
  logic        alloc;
  logic        unused_pc_low_bits;

  assign unused_pc_low_bits = ^update0_target_full_PC[UPPER_PC_LSB-1:0];

  always_comb begin
    enc_tag    = upper_of(update0_target_full_PC);
    enc_hit    = 1'b0;
    hit_index  = '0;
    free_index = '0;
    for (int i = 0; i < UPPER_PC_TABLE_ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == enc_tag) begin
        enc_hit   = 1'b1;
        hit_index = upct_idx_t'(i);
      end
    end
    // Descending scan so the lowest invalid entry is the one left standing.
    for (int i = UPPER_PC_TABLE_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_index = upct_idx_t'(i);
    end
    victim_index = (&valid_q) ? plru_victim : free_index;
    chosen_index = enc_hit ? hit_index : victim_index;
    alloc        = update0_valid && !enc_hit;
  end

  plru_8way u_plru (
    .state        (plru_q),
    .touch0_valid (read_valid),
    .touch0_index (read_index),
    .touch1_valid (update0_valid),
    .touch1_index (chosen_index),
    .next_state   (plru_d),
    .victim       (plru_victim)
  );

  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    if (alloc) begin
      tag_d[victim_index]   = enc_tag;
      valid_d[victim_index] = 1'b1;
    end

    // Reading the post-write table gives write-first behaviour on a same-index collision.
    read_upper_PC_d = read_valid ? tag_d[read_index] : read_upper_PC_q;

    update1_valid_d      = update0_valid;
    update1_upct_index_d = update0_valid ? chosen_index : update1_upct_index_q;
    update1_hit_d        = update0_valid ? enc_hit      : update1_hit_q;
  end

`ifdef UPCT_PERF_COUNTERS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (update0_valid && enc_hit && hit_count_q != '1)   hit_count_d  = hit_count_q + 32'd1;
    if (update0_valid && !enc_hit && miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the table array is reset because unwritten entries are readable and must return 0.
      for (int i = 0; i < UPPER_PC_TABLE_ENTRIES; i++) tag_q[i] <= '0;
      valid_q              <= '0;
      plru_q               <= '0;
      read_upper_PC_q      <= '0;
      update1_valid_q      <= 1'b0;
      update1_upct_index_q <= '0;
      update1_hit_q        <= 1'b0;
    end else begin
      for (int i = 0; i < UPPER_PC_TABLE_ENTRIES; i++) tag_q[i] <= tag_d[i];
      valid_q              <= valid_d;
      plru_q               <= plru_d;
      read_upper_PC_q      <= read_upper_PC_d;
      update1_valid_q      <= update1_valid_d;
      update1_upct_index_q <= update1_upct_index_d;
      update1_hit_q        <= update1_hit_d;
    end
  end

  assign read_upper_PC      = read_upper_PC_q;
  assign update1_valid      = update1_valid_q;
  assign update1_upct_index = update1_upct_index_q;
  assign update1_hit        = update1_hit_q;

endmodule
